// File: rtl/iserdes_pkg.sv
// iserdes_pkg: shared FSM state type and legal width bounds for iserdes_sdr.
package iserdes_pkg;
  typedef enum logic [1:0] {S_FILL, S_RUN, S_SLIP} state_t;
  localparam int DATA_WIDTH_MIN = 2;
  localparam int DATA_WIDTH_MAX = 8;
endpackage

// File: rtl/iserdes_sdr.sv
// iserdes_sdr: SDR input deserializer with BITSLIP word alignment.
// Optional XIL_OVERRIDE_EN adds Q_f/Q_v registers that can force Q from the testbench.
module iserdes_sdr
  import iserdes_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] INIT_Q = '0
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  CE,
  input  logic                  D,
  input  logic                  BITSLIP,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  Q_VLD
);
  localparam int CW = $clog2(DATA_WIDTH);
  if (DATA_WIDTH < DATA_WIDTH_MIN || DATA_WIDTH > DATA_WIDTH_MAX) begin : g_bad_width
    $error("iserdes_sdr: DATA_WIDTH must be 2..8");
  end
  state_t                state, state_nx;
  logic [DATA_WIDTH-2:0] sh;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] q_r, word;
  logic                  slip, done;
  assign word = {sh, D};
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) state <= S_FILL;
    else state <= state_nx;
  // FILL and SLIP both leave on the next completed word; only RUN accepts a slip
  always_comb
    state_nx = (state == S_RUN) ? (slip ? S_SLIP : S_RUN) : (done ? S_RUN : state);
  always_comb begin
    slip = CE && BITSLIP && (state == S_RUN);
    done = CE && !slip && (cnt == CW'(DATA_WIDTH - 1));
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      sh    <= '0;
      cnt   <= '0;
      q_r   <= INIT_Q;
      Q_VLD <= 1'b0;
    end else begin
      Q_VLD <= done;
      if (CE) begin
        sh  <= word[DATA_WIDTH-2:0];
        cnt <= done ? '0 : (slip ? cnt : cnt + CW'(1));
      end
      if (done) q_r <= word;
    end
`ifdef XIL_OVERRIDE_EN
  logic                  Q_f = 1'b0;
  logic [DATA_WIDTH-1:0] Q_v = '0;
  assign Q = Q_f ? Q_v : q_r;
`else
  assign Q = q_r;
`endif
endmodule
